// File: rtl/pipelined_cla_adder_pkg.sv
// Package for the pipelined carry-lookahead adder.
// Holds the lookahead group width, the per-slice propagate/generate helper
// and the width-independent control part of a pipeline stage record. The
// top level wraps the control record with WIDTH-sized data vectors to form
// its full stage_t.
package cla_pkg;

   localparam int GROUP_W = 4;

   // Per-bit propagate and generate of one lookahead group.
   typedef struct packed {
      logic [GROUP_W-1:0] p;
      logic [GROUP_W-1:0] g;
   } pg_t;

   // Control and flag bits carried alongside the data in every stage.
   typedef struct packed {
      logic valid;
      logic carry;    // carry out of the highest group resolved so far
      logic msb_a;    // operand A sign bit
      logic msb_b;    // conditioned operand B sign bit
      logic ovf;      // meaningful only once the top group is resolved
   } stage_ctl_t;

   function automatic pg_t group_pg(input logic [GROUP_W-1:0] a,
                                    input logic [GROUP_W-1:0] b);
      pg_t r;
      r.p = a ^ b;
      r.g = a & b;
      return r;
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_group.sv
// cla_group: combinational 4-bit carry-lookahead slice.
// Ports:
//   a, b   : group operand bits (b already conditioned for subtract)
//   c      : carry into the group
//   s      : 4 sum bits
//   c_out  : carry out of the group
//   p_grp  : group propagate (all four bits propagate)
//   g_grp  : group generate (carry produced inside the group)
module cla_group
   import cla_pkg::*;
(
   input  logic [GROUP_W-1:0] a,
   input  logic [GROUP_W-1:0] b,
   input  logic               c,
   output logic [GROUP_W-1:0] s,
   output logic               c_out,
   output logic               p_grp,
   output logic               g_grp
);

   pg_t pg;
   logic [GROUP_W-1:0] c_bit;

   assign pg = group_pg(a, b);

   // Every internal carry is a flat sum of products of p/g and c, so no
   // carry ripples through another.
   always_comb begin
      c_bit    = '0;
      c_bit[0] = c;
      c_bit[1] = pg.g[0] | (pg.p[0] & c);
      c_bit[2] = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & c);
      c_bit[3] = pg.g[2] | (pg.p[2] & pg.g[1]) | (pg.p[2] & pg.p[1] & pg.g[0])
               | (pg.p[2] & pg.p[1] & pg.p[0] & c);
   end

   assign g_grp = pg.g[3] | (pg.p[3] & pg.g[2]) | (pg.p[3] & pg.p[2] & pg.g[1])
                | (pg.p[3] & pg.p[2] & pg.p[1] & pg.g[0]);
   assign p_grp = &pg.p;

   assign s     = pg.p ^ c_bit;
   assign c_out = g_grp | (p_grp & c);

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor resolving one 4-bit
// lookahead group per pipeline stage, with a valid/ready handshake and a
// single global stall.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (in_ready = pipeline enable)
//   a, b, cin, sub      : operands; sub=1 computes a - b - cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry (no-borrow on subtract), signed overflow
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NGROUPS = WIDTH / GROUP_W;

   if (WIDTH < GROUP_W || (WIDTH % GROUP_W) != 0) begin : g_width_check
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of 4");
   end

   typedef struct packed {
      stage_ctl_t       ctl;
      logic [WIDTH-1:0] sum;     // low groups resolved so far
      logic [WIDTH-1:0] rem_a;   // operand A, upper groups still pending
      logic [WIDTH-1:0] rem_b;   // conditioned operand B
   } stage_t;

   logic   en;
   stage_t entry;
   stage_t tail;

   // Subtract is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
   always_comb begin
      entry           = '0;
      entry.ctl.valid = in_valid;
      entry.ctl.carry = cin ^ sub;
      entry.ctl.msb_a = a[WIDTH-1];
      entry.ctl.msb_b = b[WIDTH-1] ^ sub;
      entry.rem_a     = a;
      entry.rem_b     = b ^ {WIDTH{sub}};
   end

   for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
      stage_t               in_s;
      stage_t               nxt;
      stage_t               q;
      logic [GROUP_W-1:0]   s;
      logic                 c_out;
      logic                 p_grp;
      logic                 g_grp;

      if (k == 0) begin : g_first
         assign in_s = entry;
      end else begin : g_chain
         assign in_s = g_stage[k-1].q;
      end

      cla_group u_group (
         .a     (in_s.rem_a[GROUP_W*k +: GROUP_W]),
         .b     (in_s.rem_b[GROUP_W*k +: GROUP_W]),
         .c     (in_s.ctl.carry),
         .s     (s),
         .c_out (c_out),
         .p_grp (p_grp),
         .g_grp (g_grp)
      );

      // Carry forward via group P/G; c_out cross-feeds the overflow term.
      // Carry into the MSB is recovered as msb_a ^ msb_b ^ sum_msb; this is
      // only the true MSB in the last group, which is the only one read.
      always_comb begin
         nxt                            = in_s;
         nxt.sum[GROUP_W*k +: GROUP_W]  = s;
         nxt.ctl.carry                  = g_grp | (p_grp & in_s.ctl.carry);
         nxt.ctl.ovf                    = in_s.ctl.msb_a ^ in_s.ctl.msb_b ^ s[GROUP_W-1] ^ c_out;
      end

      // ---- stage k register boundary ----
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (en) begin
            q <= nxt;
         end
      end
   end

   assign tail = g_stage[NGROUPS-1].q;

   // Single stall for the whole pipe: advance unless a result is stuck.
   assign en        = ~tail.ctl.valid | out_ready;
   assign in_ready  = en;

   assign out_valid = tail.ctl.valid;
   assign sum       = tail.sum;
   assign cout      = tail.ctl.carry;
   assign ovf       = tail.ctl.ovf;

   // Operand copies and sign bits are fully consumed by the last stage.
   logic unused_tail;
   assign unused_tail = ^{tail.rem_a, tail.rem_b, tail.ctl.msb_a, tail.ctl.msb_b};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at WIDTH=16: the driver pushes the
// reference result on each accept, a monitor pops and compares on each
// output transfer.
module tb_pipelined_cla_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   rand_ready = 1'b0;
   res_t exp_q[$];
   int   pop_cyc[$];
   res_t mon_e;

   pipelined_cla_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed readings.
   function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic c, input logic s);
      res_t r;
      int ua, ub, sa, sb, ci, ur, sr;
      logic signed [W-1:0] ta, tb2;
      ta = xa;
      tb2 = xb;
      ua = int'(xa);
      ub = int'(xb);
      sa = int'(ta);
      sb = int'(tb2);
      ci = c ? 1 : 0;
      if (!s) begin
         ur = ua + ub + ci;
         sr = sa + sb + ci;
         r.cout = (ur > 65535);
      end else begin
         ur = ua - ub - ci;
         sr = sa - sb - ci;
         r.cout = (ua >= ub + ci);
      end
      r.sum = ur[W-1:0];
      r.ovf = (sr > 32767) || (sr < -32768);
      return r;
   endfunction

   // Monitor: a transfer happens at the next rising edge when both are high.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0h expected none", sum);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", 32'({sum, cout, ovf}), 32'(mon_e));
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic xc, input logic xs, output int acc_cyc);
      bit got;
      got = 1'b0;
      acc_cyc = -1;
      a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         step();
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end else begin
         exp_q.push_back(model(xa, xb, xc, xs));
         acc_cyc = cyc;
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_rand(output int acc_cyc);
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc_cyc);
   endtask

   task automatic wait_out_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s: got out_valid=0 expected 1", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, first;
      res_t held;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_sum", 32'(sum), 0);
      chk("rst_flags", 32'({cout, ovf}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      step();
      out_ready = 1'b1;

      // Latency of the first directed operation
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk("latency_gap", 32'(out_valid), 0);
      end
      @(negedge clk);
      chk("latency_hit", 32'(out_valid), 1);
      step();

      // Directed corner vectors
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
      send(16'h8000, 16'h8000, 1'b0, 1'b0, acc);
      send(16'h0005, 16'h0007, 1'b0, 1'b1, acc);
      send(16'h0007, 16'h0005, 1'b1, 1'b1, acc);
      send(16'h0000, 16'h0000, 1'b1, 1'b1, acc);
      idle(8);

      // Back-to-back: accepted every cycle, emerging every cycle after 4
      pop_cyc.delete();
      first = 0;
      for (int i = 0; i < 8; i++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         send(a, b, cin, sub, acc);
         if (i == 0) first = acc;
         else chk("b2b_accept_cycle", acc, first + i);
      end
      idle(8);
      chk("b2b_count", pop_cyc.size(), 8);
      for (int i = 0; i < pop_cyc.size() && i < 8; i++)
         chk("b2b_out_cycle", pop_cyc[i], first + 4 + i);

      // Stall with a result at the output and two more behind it
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_rand(acc);
      wait_out_valid("stall_wait");
      held = {sum, cout, ovf};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 0);
         chk("stall_out_valid", 32'(out_valid), 1);
         chk("stall_hold", 32'({sum, cout, ovf}), 32'(held));
      end
      step();
      out_ready = 1'b1;
      idle(8);
      chk("stall_drained", exp_q.size(), 0);

      // Random traffic with random back-pressure and input gaps
      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         send_rand(acc);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      idle(10);
      chk("random_drained", exp_q.size(), 0);

      // Asynchronous reset with operations in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_rand(acc);
      wait_out_valid("reset_wait");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_sum", 32'(sum), 0);
      chk("async_rst_in_ready", 32'(in_ready), 1);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_stale", 32'(out_valid), 0);
      end
      step();
      send(16'h1234, 16'h1111, 1'b0, 1'b0, acc);
      idle(8);
      chk("final_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- One group is resolved per pipeline stage. The carry is registered between groups, and unresolved operand bits are carried forward with it.
- Valid/ready handshake on input and output gives full throughput of one operation per cycle, with back-pressure.
- Datapath arithmetic primitive for the HW-series designs; replaces ad-hoc combinational adders wherever WIDTH > 4 or timing requires registers.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; otherwise elaboration fails via an $error check.
- NGROUPS, WIDTH/4, derived local parameter: number of 4-bit groups, which equals the number of pipeline stages.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- in_valid  input  1  An operation is presented this cycle.
- in_ready  output  1  Block accepts the operation this cycle.
- a  input  WIDTH  Operand A.
- b  input  WIDTH  Operand B.
- cin  input  1  Carry-in for add; borrow-in for subtract.
- sub  input  1  0: add, computing A+B+cin. 1: subtract, computing A-B-cin.
- out_valid  output  1  Result is valid.
- out_ready  input  1  Consumer accepts the result this cycle.
- sum  output  WIDTH  Result, modulo 2^WIDTH.
- cout  output  1  Add: carry-out. Subtract: 1 means no borrow (A >= B+cin, unsigned).
- ovf  output  1  Two's-complement signed overflow of the operation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear immediately, so out_valid=0.
  - sum, cout and ovf read 0; data registers are cleared too.
  - in_ready is 1 while rst_n=1 and the pipe is empty.
  - Reset mid-operation discards all in-flight operations; none emerge after reset release.
- Operand conditioning at acceptance:
  - If sub=1, use b' = ~b and c0 = ~cin.
  - Otherwise, use b' = b and c0 = cin.
  - The internal computation is always a + b' + c0.
- Stage k (k = 0..NGROUPS-1):
  - Takes group k bits [4k+3:4k] and the incoming carry.
  - Computes generate G = a&b' and propagate P = a^b' with full 4-bit lookahead.
  - Produces 4 sum bits and the group carry-out.
  - Registers: sum bits resolved so far, the carry, unresolved operand bits, the MSB operands needed for ovf, and a valid bit.
- Latency: exactly NGROUPS cycles from the accepting edge to out_valid=1 with that result (4 cycles at WIDTH=16).
- Outputs are driven directly from the final stage registers.
- Final-stage flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Handshake:
  - Global pipeline enable: en = ~out_valid | out_ready.
  - in_ready = en.
  - An operation is accepted when in_valid & in_ready.
  - When en=0, every stage register holds its value, including data, valid and flags.
  - When en=1, every stage advances. A bubble (valid=0) enters stage 0 if there is no accept.
  - Transfer out occurs when out_valid & out_ready.
  - While stalled, sum/cout/ovf remain stable.
  - in_ready may depend combinationally on out_ready. No other combinational input-to-output paths exist.
- Throughput: one operation per cycle while out_ready=1. Results emerge in acceptance order; there is no reordering.
- Boundary cases:
  - Bubbles in the pipe are not compacted under stall. This is accepted (simple global stall).
  - in_valid with in_ready=0: operands are ignored, and the source must hold them.
  - WIDTH=4: single stage, latency 1.
  - Carry-out from bit WIDTH-1 never wraps back into bit 0.
- Arithmetic is unsigned modulo 2^WIDTH for sum. ovf interprets the operands as signed.

Decomposition:
- Package cla_pkg holds:
  - the GROUP_W=4 constant;
  - the function computing group P/G for a 4-bit slice;
  - a stage_t struct (valid, partial sum, carry, remaining a/b', msb_a, msb_b).
  - The struct is parametrised via packed widths at the top level.
- Sub-module cla_group: combinational, 4-bit.
  - Inputs: a, b, c.
  - Outputs: s[3:0], c_out, and group P/G for later use in multi-level lookahead.
  - Instantiated NGROUPS times in a generate loop, one per stage.

Test Plan:
- WIDTH=16, add a=16'hFFFF b=16'h0001 cin=0 -> 4 cycles later sum=16'h0000 cout=1 ovf=0.
- Add a=16'h7FFF b=16'h0001 cin=0 -> sum=16'h8000 cout=0 ovf=1. Add a=16'h8000 b=16'h8000 -> sum=16'h0000 cout=1 ovf=1.
- Sub a=16'h0005 b=16'h0007 cin=0 -> sum=16'hFFFE cout=0 ovf=0. Sub a=16'h0007 b=16'h0005 cin=1 -> sum=16'h0001 cout=1 ovf=0.
- Back-to-back: 8 consecutive accepts with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model; in_ready stays 1 throughout.
- Stall: hold out_ready=0 for 5 cycles with a result at the output -> in_ready=0, sum/cout/ovf unchanged for all 5 cycles. Release -> drain in order with no loss or duplication.
- Reset mid-operation: 3 operations in flight, assert rst_n=0 asynchronously (between edges) -> out_valid drops to 0 immediately. After release, no stale result appears; a new add 16'h1234+16'h1111 -> 16'h2345 cout=0.
